// File: rtl/reset_req_gen.sv
// reset_req_gen: turns a debounced push-button, a CPU soft-reset strobe and a
// watchdog timeout into a single fixed-width active-low reset request pulse,
// followed by a holdoff window during which new requests are dropped.
module reset_req_gen #(
  parameter int unsigned CLK_DIV        = 32,
  parameter int unsigned DEBOUNCE_TICKS = 16,
  parameter int unsigned PULSE_TICKS    = 64,
  parameter int unsigned HOLDOFF_TICKS  = 256,
  parameter int unsigned WDT_TICKS      = 65535
) (
  input  logic       CLK,
  input  logic       SYS_RESET_N,
  input  logic       KEY_N,
  input  logic       SOFT_REQ,
  input  logic       WDT_EN,
  input  logic       WDT_KICK,
  output logic       RESET_REQ_N,
  output logic [1:0] CAUSE,
  output logic       BUSY
);

  localparam int unsigned TMAX = (PULSE_TICKS > HOLDOFF_TICKS) ? PULSE_TICKS : HOLDOFF_TICKS;
  localparam int unsigned PW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned DW   = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int unsigned WW   = $clog2(WDT_TICKS + 1);

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_KEY  = 2'b01;
  localparam logic [1:0] CAUSE_SOFT = 2'b10;
  localparam logic [1:0] CAUSE_WDT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [TW-1:0] st_cnt;
  logic          key_meta;
  logic          key_sync;
  logic          key_acc;
  logic [DW-1:0] deb_cnt;
  logic [WW-1:0] wdt_cnt;

  logic          tick_c;
  logic          key_diff_c;
  logic          key_evt_c;
  logic          wdt_evt_c;

  // Prescaler terminal count marks the tick cycle
  assign tick_c     = (presc == PW'(CLK_DIV - 1));
  assign key_diff_c = (key_sync != key_acc);
  // A press is accepted on the tick that completes the stable-low run
  assign key_evt_c  = tick_c && key_diff_c && !key_sync &&
                      (deb_cnt == DW'(DEBOUNCE_TICKS - 1));
  // Expiry fires on the tick that brings the count to its limit
  assign wdt_evt_c  = (state == ST_IDLE) && WDT_EN && !WDT_KICK && tick_c &&
                      (wdt_cnt == WW'(WDT_TICKS - 1));

  // Two-flop synchroniser for the asynchronous push-button
  always_ff @(posedge CLK) begin
    if (!SYS_RESET_N) begin
      key_meta <= 1'b1;
      key_sync <= 1'b1;
    end else begin
      key_meta <= KEY_N;
      key_sync <= key_meta;
    end
  end

  // Debounce: accepted level follows the synchronised key after a stable run of ticks
  always_ff @(posedge CLK) begin
    if (!SYS_RESET_N) begin
      key_acc <= 1'b1;
      deb_cnt <= '0;
    end else if (tick_c) begin
      if (!key_diff_c) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DW'(DEBOUNCE_TICKS - 1)) begin
        key_acc <= key_sync;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end
  end

  // Watchdog counter: runs on ticks only while enabled and idle, saturates at the limit
  always_ff @(posedge CLK) begin
    if (!SYS_RESET_N) begin
      wdt_cnt <= '0;
    end else if ((state != ST_IDLE) || !WDT_EN || WDT_KICK) begin
      wdt_cnt <= '0;
    end else if (tick_c && (wdt_cnt != WW'(WDT_TICKS))) begin
      wdt_cnt <= wdt_cnt + WW'(1);
    end
  end

  // Main FSM with registered outputs; prescaler restarts on every state entry
  always_ff @(posedge CLK) begin
    if (!SYS_RESET_N) begin
      state       <= ST_IDLE;
      presc       <= '0;
      st_cnt      <= '0;
      RESET_REQ_N <= 1'b1;
      CAUSE       <= CAUSE_NONE;
      BUSY        <= 1'b0;
    end else begin
      presc <= tick_c ? '0 : presc + PW'(1);
      unique case (state)
        ST_IDLE: begin
          if (wdt_evt_c || key_evt_c || SOFT_REQ) begin
            state       <= ST_ASSERT;
            presc       <= '0;
            st_cnt      <= '0;
            RESET_REQ_N <= 1'b0;
            BUSY        <= 1'b1;
            if (wdt_evt_c) begin
              CAUSE <= CAUSE_WDT;
            end else if (key_evt_c) begin
              CAUSE <= CAUSE_KEY;
            end else begin
              CAUSE <= CAUSE_SOFT;
            end
          end
        end
        ST_ASSERT: begin
          if (tick_c) begin
            if (st_cnt == TW'(PULSE_TICKS - 1)) begin
              state       <= ST_HOLDOFF;
              presc       <= '0;
              st_cnt      <= '0;
              RESET_REQ_N <= 1'b1;
            end else begin
              st_cnt <= st_cnt + TW'(1);
            end
          end
        end
        ST_HOLDOFF: begin
          if (tick_c) begin
            if (st_cnt == TW'(HOLDOFF_TICKS - 1)) begin
              state  <= ST_IDLE;
              presc  <= '0;
              st_cnt <= '0;
              BUSY   <= 1'b0;
            end else begin
              st_cnt <= st_cnt + TW'(1);
            end
          end
        end
        default: begin
          state       <= ST_IDLE;
          presc       <= '0;
          st_cnt      <= '0;
          RESET_REQ_N <= 1'b1;
          BUSY        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_req_gen.sv
// tb_reset_req_gen: directed stimulus pushes expected pulses into a queue; a
// negedge monitor pops one per observed RESET_REQ_N pulse and checks its start
// cycle, cause, low width and busy width.
module tb_reset_req_gen;

  localparam int unsigned CLK_DIV        = 4;
  localparam int unsigned DEBOUNCE_TICKS = 3;
  localparam int unsigned PULSE_TICKS    = 5;
  localparam int unsigned HOLDOFF_TICKS  = 10;
  localparam int unsigned WDT_TICKS      = 20;

  localparam int LOW_W  = 20;  // 5 ticks * 4 cycles
  localparam int BUSY_W = 60;  // (5 + 10) ticks * 4 cycles

  logic       CLK;
  logic       SYS_RESET_N;
  logic       KEY_N;
  logic       SOFT_REQ;
  logic       WDT_EN;
  logic       WDT_KICK;
  logic       RESET_REQ_N;
  logic [1:0] CAUSE;
  logic       BUSY;

  typedef struct {
    int         start;
    logic [1:0] cause;
    bit         full;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   t0     = 0;
  bit   mon_active = 0;
  logic prev_n = 1'b1;
  int   low_cnt  = 0;
  int   busy_cnt = 0;

  reset_req_gen #(
    .CLK_DIV       (CLK_DIV),
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
    .PULSE_TICKS   (PULSE_TICKS),
    .HOLDOFF_TICKS (HOLDOFF_TICKS),
    .WDT_TICKS     (WDT_TICKS)
  ) dut (
    .CLK        (CLK),
    .SYS_RESET_N(SYS_RESET_N),
    .KEY_N      (KEY_N),
    .SOFT_REQ   (SOFT_REQ),
    .WDT_EN     (WDT_EN),
    .WDT_KICK   (WDT_KICK),
    .RESET_REQ_N(RESET_REQ_N),
    .CAUSE      (CAUSE),
    .BUSY       (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc - t0);
    end
  endtask

  // Monitor: detect pulse starts, measure widths, compare against the queue
  always @(negedge CLK) begin
    if (SYS_RESET_N === 1'b0) begin
      if (mon_active && cur.start >= 0) begin
        chk("pulse_aborted_unexpectedly", 32'(cur.full), 32'd0);
      end
      mon_active = 0;
      prev_n     = 1'b1;
    end else begin
      if (!mon_active && prev_n === 1'b1 && RESET_REQ_N === 1'b0) begin
        mon_active = 1;
        low_cnt    = 0;
        busy_cnt   = 0;
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse_start", 32'(cyc - t0), 32'hFFFF_FFFF);
          cur.start = -1;
        end else begin
          cur = exp_q.pop_front();
          chk("pulse_start_cycle", 32'(cyc - t0), 32'(cur.start));
          chk("pulse_cause", 32'(CAUSE), 32'(cur.cause));
        end
      end
      if (mon_active) begin
        if (RESET_REQ_N === 1'b0) low_cnt++;
        if (BUSY === 1'b1) begin
          busy_cnt++;
        end else begin
          if (cur.start >= 0) begin
            chk("abort_missed", 32'(cur.full), 32'd1);
            chk("low_width", 32'(low_cnt), 32'(LOW_W));
            chk("busy_width", 32'(busy_cnt), 32'(BUSY_W));
            chk("cause_held", 32'(CAUSE), 32'(cur.cause));
          end
          mon_active = 0;
        end
      end
      prev_n = RESET_REQ_N;
    end
  end

  task automatic do_reset();
    SYS_RESET_N = 1'b0;
    KEY_N       = 1'b1;
    SOFT_REQ    = 1'b0;
    WDT_EN      = 1'b0;
    WDT_KICK    = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_reset_req_n", 32'(RESET_REQ_N), 32'd1);
    chk("rst_cause", 32'(CAUSE), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    @(negedge CLK);
    SYS_RESET_N = 1'b1;
    t0 = cyc;
  endtask

  // Advance to relative cycle n (cycle 0 is the release negedge)
  task automatic goto(input int n);
    while (cyc - t0 < n) @(negedge CLK);
  endtask

  task automatic push(input int start, input logic [1:0] cause, input bit full);
    exp_t e;
    e.start = start;
    e.cause = cause;
    e.full  = full;
    exp_q.push_back(e);
  endtask

  task automatic strobe_soft();
    SOFT_REQ = 1'b1;
    @(negedge CLK);
    SOFT_REQ = 1'b0;
  endtask

  initial begin
    // Soft request, plus soft strobes during ASSERT and HOLDOFF that must be dropped
    do_reset();
    goto(5);  push(6, 2'b10, 1'b1); strobe_soft();
    goto(16); strobe_soft();
    goto(46); strobe_soft();
    goto(120);

    // Short key press (2 ticks) is discarded
    do_reset();
    goto(2);  KEY_N = 1'b0;
    goto(10); KEY_N = 1'b1;
    goto(60);

    // Long press accepted once; held past holdoff gives no repeat; release + re-press
    do_reset();
    goto(2);   KEY_N = 1'b0; push(16, 2'b01, 1'b1);
    goto(150); KEY_N = 1'b1;
    goto(200); KEY_N = 1'b0; push(212, 2'b01, 1'b1);
    goto(220); KEY_N = 1'b1;
    goto(300);

    // Watchdog without kicks fires after 20 ticks, and again after holdoff
    do_reset();
    WDT_EN = 1'b1; push(80, 2'b11, 1'b1); push(220, 2'b11, 1'b1);
    goto(225); WDT_EN = 1'b0;
    goto(300);

    // Watchdog kicked every 10 ticks never fires
    do_reset();
    WDT_EN = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      goto(40 * k);
      WDT_KICK = 1'b1;
      @(negedge CLK);
      WDT_KICK = 1'b0;
    end
    goto(1010); WDT_EN = 1'b0;
    goto(1020);

    // Soft request coincident with watchdog expiry: watchdog wins
    do_reset();
    WDT_EN = 1'b1;
    goto(79); push(80, 2'b11, 1'b1); strobe_soft();
    goto(90); WDT_EN = 1'b0;
    goto(160);

    // Reset mid-ASSERT aborts the pulse with no residual event
    do_reset();
    goto(5);  push(6, 2'b10, 1'b0); strobe_soft();
    goto(15); SYS_RESET_N = 1'b0;
    @(negedge CLK);
    chk("abort_reset_req_n", 32'(RESET_REQ_N), 32'd1);
    chk("abort_cause", 32'(CAUSE), 32'd0);
    chk("abort_busy", 32'(BUSY), 32'd0);
    @(negedge CLK);
    SYS_RESET_N = 1'b1;
    t0 = cyc;
    goto(100);
    chk("post_abort_cause", 32'(CAUSE), 32'd0);
    chk("post_abort_reset_req_n", 32'(RESET_REQ_N), 32'd1);

    chk("expected_pulses_left", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reset_req_gen.md
RESET_REQ_GEN -- requirements
Module: reset_req_gen

Interface
REQ-001 SHALL have parameter CLK_DIV, default 32, meaning CLK cycles per tick (>=2).
REQ-002 SHALL have parameter DEBOUNCE_TICKS, default 16, meaning the stable-level ticks needed to accept a key change.
REQ-003 SHALL have parameter PULSE_TICKS, default 64, meaning the RESET_REQ_N low width in ticks.
REQ-004 SHALL have parameter HOLDOFF_TICKS, default 256, meaning the post-pulse ticks during which requests are ignored.
REQ-005 SHALL have parameter WDT_TICKS, default 65535, meaning the watchdog timeout in ticks.
REQ-006 SHALL have port CLK  in  1  system clock; the only clock.
REQ-007 SHALL have port SYS_RESET_N  in  1  reset; synchronous, active-low.
REQ-008 SHALL have port KEY_N  in  1  asynchronous push-button, low = pressed.
REQ-009 SHALL have port SOFT_REQ  in  1  single-cycle CPU soft-reset strobe.
REQ-010 SHALL have port WDT_EN  in  1  watchdog enable.
REQ-011 SHALL have port WDT_KICK  in  1  single-cycle watchdog service strobe.
REQ-012 SHALL have port RESET_REQ_N  out  1  reset request pulse, active-low; feeds the downstream reset-stretcher SYS_RESET_N.
REQ-013 SHALL have port CAUSE  out  2  last cause: 00 none, 01 key, 10 soft, 11 watchdog.
REQ-014 SHALL have port BUSY  out  1  high while in ASSERT or HOLDOFF.

Function
REQ-015 SHALL synchronise KEY_N through two flip-flops before any use.
REQ-016 SHALL generate an internal TICK one cycle every CLK_DIV cycles, using a prescaler that restarts at every FSM state entry.
REQ-017 SHALL accept a key press after the synchronised key has been low for DEBOUNCE_TICKS consecutive ticks; shorter lows SHALL be discarded.
REQ-018 SHALL produce exactly one key event per accepted press, and SHALL not re-arm until the key has been high for DEBOUNCE_TICKS consecutive ticks.
REQ-019 SHALL increment the watchdog count on each TICK while WDT_EN=1 and the FSM is in IDLE.
REQ-020 SHALL clear the watchdog count on WDT_KICK, on WDT_EN=0, and in ASSERT/HOLDOFF.
REQ-021 SHALL raise a watchdog event when the watchdog count reaches WDT_TICKS.
REQ-022 SHALL implement FSM states IDLE, ASSERT and HOLDOFF.
REQ-023 SHALL go IDLE -> ASSERT on the edge following any event; RESET_REQ_N SHALL be low from that edge, giving one-cycle latency.
REQ-024 SHALL hold RESET_REQ_N low for exactly PULSE_TICKS*CLK_DIV cycles, then go ASSERT -> HOLDOFF.
REQ-025 SHALL remain in HOLDOFF for exactly HOLDOFF_TICKS*CLK_DIV cycles, then go HOLDOFF -> IDLE.
REQ-026 SHALL drop (not queue) events occurring in ASSERT/HOLDOFF; key debounce tracking SHALL continue.
REQ-027 SHALL resolve simultaneous events by priority watchdog > key > soft.
REQ-028 SHALL latch CAUSE on ASSERT entry and hold it until the next accepted event.
REQ-029 SHALL size all counters to their parameters, saturating without wrap.

Reset
REQ-030 SHALL, while SYS_RESET_N=0 at a CLK edge, set RESET_REQ_N=1, CAUSE=00, BUSY=0, state=IDLE, all counters=0, synchroniser and debounce state = released.
REQ-031 SHALL abort any in-progress pulse or holdoff on reset, with no residual event after release.

Verification (params CLK_DIV=4, DEBOUNCE_TICKS=3, PULSE_TICKS=5, HOLDOFF_TICKS=10, WDT_TICKS=20)
REQ-032 SHALL cover: SOFT_REQ in IDLE -> RESET_REQ_N low next cycle for 20 cycles, CAUSE=10, BUSY high for 60 cycles.
REQ-033 SHALL cover: KEY_N low 2 ticks -> no pulse; low 3+ ticks -> one pulse, CAUSE=01; key held past HOLDOFF -> no second pulse until release plus re-press.
REQ-034 SHALL cover: WDT_EN=1 without kicks -> pulse after 20 ticks, CAUSE=11; kick every 10 ticks -> no pulse over 1000 cycles.
REQ-035 SHALL cover: SOFT_REQ coincident with watchdog expiry -> single pulse, CAUSE=11.
REQ-036 SHALL cover: SOFT_REQ during HOLDOFF -> ignored, IDLE reached on schedule, no later pulse.
REQ-037 SHALL cover: SYS_RESET_N low mid-ASSERT -> next edge RESET_REQ_N=1, CAUSE=00, BUSY=0.
